dm_requester: RTL and testbench
===============================

Name: dm_requester

Overview:
- Initiator side of the data-memory (DM) port. It accepts one load/store/push/pop command at a time from the CPU execute stage over a valid/ready handshake.
- It owns the architectural stack pointer and drives the DM strobes, address and write data for exactly one cycle per command.
- For loads and pops it captures the DM read data after the DM read latency, then returns a response over a valid/ready handshake.
- It detects stack overflow and underflow and blocks the DM access in those cases.

Parameters:
- DATA_W, 16, data and address width.
- SP_INIT, 16'hFFFF, stack pointer value after reset (empty stack); the stack grows downward.
- SP_LIMIT, 16'hFF00, lowest address a push may write.
- READ_LAT, 1, cycles from the DM load/pop strobe to valid data on dm_out (range 1..3).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  0=LOAD, 1=STORE, 2=PUSH, 3=POP
- cmd_addr  in  DATA_W  address for LOAD/STORE (ignored for PUSH/POP)
- cmd_data  in  DATA_W  write data for STORE/PUSH
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  DATA_W  read data (0 for STORE/PUSH and on error)
- rsp_err  out  1  overflow/underflow on this command
- dm_load, dm_store, dm_push, dm_pop  out  1 each  DM strobes, one-hot or all zero
- dm_rez  out  DATA_W  DM address for LOAD/STORE
- dm_val  out  DATA_W  DM write data
- dm_sp  out  DATA_W  DM stack address for PUSH/POP
- dm_out  in  DATA_W  DM read data
- sp  out  DATA_W  current stack pointer (register value)

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: all strobes 0, cmd_ready 0, rsp_valid 0, rsp_err 0, rsp_data 0, dm_rez/dm_val/dm_sp 0.
  - State: sp=SP_INIT, FSM=IDLE.
  - An in-flight command is dropped with no response. Strobes drop immediately, not at the next edge.
  - cmd_ready rises in the first cycle after rst_n deasserts.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op/addr/data and go to ISSUE.
- ISSUE (one cycle, cmd_ready=0):
  - LOAD: dm_load=1, dm_rez=addr.
  - STORE: dm_store=1, dm_rez=addr, dm_val=data.
  - PUSH, sp>=SP_LIMIT: dm_push=1, dm_sp=sp, dm_val=data; sp<=sp-1 at the end of the cycle.
  - PUSH, sp<SP_LIMIT: overflow. No strobe, sp unchanged, error flag set.
  - POP, sp!=SP_INIT: dm_pop=1, dm_sp=sp+1; sp<=sp+1.
  - POP, sp==SP_INIT: underflow. No strobe, sp unchanged, error flag set.
  - Next state: WAIT for a LOAD or a non-error POP; RESP otherwise.
- WAIT:
  - Count READ_LAT-1 further cycles after ISSUE, then capture dm_out into rsp_data on the cycle dm_out is valid.
  - Go to RESP.
  - With READ_LAT=1, data is captured at the first edge after ISSUE.
- RESP:
  - rsp_valid=1; rsp_data/rsp_err are stable while rsp_valid=1.
  - On rsp_ready, return to IDLE; cmd_ready is 1 in the next cycle.
  - rsp_valid is held until rsp_ready, with no timeout.
- Latency, command accept to rsp_valid:
  - STORE/PUSH/error: 2 cycles.
  - LOAD/POP: 2+READ_LAT cycles.
- Strobes, address and data buses:
  - Strobes are asserted only in ISSUE, for exactly one cycle.
  - dm_rez, dm_val and dm_sp are 0 outside ISSUE.
- Arithmetic and accepted inputs:
  - sp arithmetic is modulo 2^DATA_W, but the overflow/underflow checks prevent wrap.
  - cmd_valid is ignored outside IDLE.
  - A reserved/illegal op cannot occur because cmd_op is 2 bits.
- Simultaneous events: rsp_ready and a new cmd_valid in the same RESP cycle → the command is accepted only in the following IDLE cycle. There is no bypass.

Decomposition:
- Shared package dm_pkg:
  - op encodings OP_LOAD/OP_STORE/OP_PUSH/OP_POP.
  - state encoding.
  - default SP_INIT/SP_LIMIT constants.
- One natural sub-module: dm_sp_unit, which holds the sp register, push/pop increment/decrement and overflow/underflow flags (combinational check, registered sp).
- FSM and latency counter stay in dm_requester.

Test Plan:
- Reset: hold rst_n=0, pulse it mid-WAIT of a LOAD → strobes 0 immediately, sp=16'hFFFF, rsp_valid never rises for the dropped command, cmd_ready=1 one cycle after release.
- STORE then LOAD: STORE addr 16'h0010 data 16'hBEEF → dm_store one cycle with dm_rez=16'h0010, dm_val=16'hBEEF; then LOAD 16'h0010 → rsp_data=16'hBEEF at accept+3 cycles (READ_LAT=1).
- PUSH 16'h1234, PUSH 16'h5678, POP, POP:
  - dm_sp sequence is FFFF, FFFE, FFFE, FFFF.
  - rsp_data of the pops is 5678 then 1234.
  - sp ends at FFFF.
- Underflow: POP with sp=FFFF → no dm_pop, rsp_err=1, rsp_data=0, sp stays FFFF.
- Overflow with SP_LIMIT=16'hFFFE:
  - Two pushes succeed, sp goes FFFF → FFFD.
  - Third push gives rsp_err=1, no dm_push, sp stays FFFD.
- Backpressure and latency:
  - Hold rsp_ready=0 for 5 cycles after a LOAD → rsp_valid/rsp_data stable and cmd_ready=0 throughout.
  - Repeat with READ_LAT=3 → capture occurs 3 cycles after dm_load.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory requester: command opcodes,
// FSM state encoding and default stack bounds.
package dm_pkg;

    localparam int          DM_DATA_W    = 16;
    localparam logic [15:0] SP_INIT_DEF  = 16'hFFFF;
    localparam logic [15:0] SP_LIMIT_DEF = 16'hFF00;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1,
        OP_PUSH  = 2'd2,
        OP_POP   = 2'd3
    } dm_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dm_state_e;

endpackage

// File: rtl/dm_requester_if.sv
// Bus bundle between the execute stage, the requester and the data memory.
//
// Handshakes: a transfer on cmd_* (resp. rsp_*) happens on a rising clock
// edge where valid and ready are both 1. Once the requester raises
// rsp_valid it keeps it, rsp_data and rsp_err stable until that transfer.
// The requester samples cmd_valid only while cmd_ready is 1. The dm_*
// strobes are one-shot and carry no handshake: the memory must act on them
// in the cycle they are high.
interface dm_requester_if #(
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    logic              dm_load;
    logic              dm_store;
    logic              dm_push;
    logic              dm_pop;
    logic [DATA_W-1:0] dm_rez;
    logic [DATA_W-1:0] dm_val;
    logic [DATA_W-1:0] dm_sp;
    logic [DATA_W-1:0] dm_out;

    logic [DATA_W-1:0] sp;

    // Requester side
    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, dm_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
               dm_load, dm_store, dm_push, dm_pop, dm_rez, dm_val, dm_sp, sp
    );

    // Execute-stage / memory side
    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, dm_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
               dm_load, dm_store, dm_push, dm_pop, dm_rez, dm_val, dm_sp, sp
    );

endinterface

// File: rtl/dm_sp_unit.sv
// Architectural stack pointer. The stack grows downward from SP_INIT; a push
// writes at sp then decrements, a pop increments then reads at the new sp.
// Overflow/underflow flags are combinational on the current register value
// so the FSM can suppress the memory strobe in the same cycle.
module dm_sp_unit
#(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] SP_INIT  = 16'hFFFF,
    parameter logic [DATA_W-1:0] SP_LIMIT = 16'hFF00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_sp,
    output logic [DATA_W-1:0] o_sp_inc,
    output logic              o_ovf,
    output logic              o_unf
);

    logic [DATA_W-1:0] r_sp;

    assign o_sp     = r_sp;
    assign o_sp_inc = r_sp + DATA_W'(1);
    assign o_ovf    = (r_sp < SP_LIMIT);
    assign o_unf    = (r_sp == SP_INIT);

    // Move sp only for accesses that pass the bound checks, so it never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= SP_INIT;
        end else if (i_push && !o_ovf) begin
            r_sp <= r_sp - DATA_W'(1);
        end else if (i_pop && !o_unf) begin
            r_sp <= o_sp_inc;
        end
    end

endmodule

// File: rtl/dm_requester.sv
// Initiator side of the data-memory port. Takes one command at a time,
// drives the memory strobes for a single ISSUE cycle, waits READ_LAT cycles
// for read data on loads/pops and returns a response. Pushes below the
// stack limit and pops of an empty stack are blocked and flagged.
module dm_requester
    import dm_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] SP_INIT  = SP_INIT_DEF,
    parameter logic [DATA_W-1:0] SP_LIMIT = SP_LIMIT_DEF,
    parameter int                READ_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    dm_requester_if.master bus,
    output dm_state_e      o_dbg_state
);

    // Last value of the wait counter; WAIT lasts READ_LAT cycles in total
    localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

    dm_state_e         r_state;
    dm_state_e         w_next;
    dm_op_e            r_op;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_lat_cnt;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    // Holds cmd_ready low until the first edge after reset release
    logic              r_rdy_en;

    logic              w_accept;
    logic              w_issue_err;
    logic              w_cmd_ready;
    logic              w_load;
    logic              w_store;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_rez;
    logic [DATA_W-1:0] w_val;
    logic [DATA_W-1:0] w_dsp;

    logic [DATA_W-1:0] w_sp;
    logic [DATA_W-1:0] w_sp_inc;
    logic              w_ovf;
    logic              w_unf;
    logic              w_sp_push;
    logic              w_sp_pop;

    assign w_accept    = (r_state == ST_IDLE) && r_rdy_en && bus.cmd_valid;
    assign w_sp_push   = (r_state == ST_ISSUE) && (r_op == OP_PUSH);
    assign w_sp_pop    = (r_state == ST_ISSUE) && (r_op == OP_POP);
    assign w_issue_err = (w_sp_push && w_ovf) || (w_sp_pop && w_unf);

    dm_sp_unit #(
        .DATA_W   (DATA_W),
        .SP_INIT  (SP_INIT),
        .SP_LIMIT (SP_LIMIT)
    ) u_sp (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push   (w_sp_push),
        .i_pop    (w_sp_pop),
        .o_sp     (w_sp),
        .o_sp_inc (w_sp_inc),
        .o_ovf    (w_ovf),
        .o_unf    (w_unf)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and memory-side outputs; strobes and buses only in ISSUE
    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_load      = 1'b0;
        w_store     = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_rez       = '0;
        w_val       = '0;
        w_dsp       = '0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = r_rdy_en;
                if (w_accept) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                case (r_op)
                    OP_LOAD: begin
                        w_load = 1'b1;
                        w_rez  = r_addr;
                    end
                    OP_STORE: begin
                        w_store = 1'b1;
                        w_rez   = r_addr;
                        w_val   = r_data;
                    end
                    OP_PUSH: begin
                        if (!w_ovf) begin
                            w_push = 1'b1;
                            w_dsp  = w_sp;
                            w_val  = r_data;
                        end
                    end
                    OP_POP: begin
                        if (!w_unf) begin
                            w_pop = 1'b1;
                            w_dsp = w_sp_inc;
                        end
                    end
                    default: ;
                endcase
                if ((r_op == OP_LOAD) || ((r_op == OP_POP) && !w_unf)) begin
                    w_next = ST_WAIT;
                end else begin
                    w_next = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Command latch, latency counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en   <= 1'b0;
            r_op       <= OP_LOAD;
            r_addr     <= '0;
            r_data     <= '0;
            r_lat_cnt  <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_accept) begin
                r_op       <= dm_op_e'(bus.cmd_op);
                r_addr     <= bus.cmd_addr;
                r_data     <= bus.cmd_data;
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b0;
            end
            if (r_state == ST_ISSUE) begin
                r_lat_cnt <= '0;
                r_rsp_err <= w_issue_err;
            end
            if (r_state == ST_WAIT) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
                if (r_lat_cnt == LAT_LAST) begin
                    r_rsp_data <= bus.dm_out;
                end
            end
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.dm_load   = w_load;
    assign bus.dm_store  = w_store;
    assign bus.dm_push   = w_push;
    assign bus.dm_pop    = w_pop;
    assign bus.dm_rez    = w_rez;
    assign bus.dm_val    = w_val;
    assign bus.dm_sp     = w_dsp;
    assign bus.sp        = w_sp;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dm_requester.sv
// Directed bench for dm_requester. Two instances share one stimulus driver
// and one data-memory model; sel picks which one is active:
//   dut_a: SP_LIMIT=FFFE, READ_LAT=1   dut_b: defaults, READ_LAT=3
module tb_dm_requester;
    import dm_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic        sel = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_data = '0;
    logic        rsp_ready = 1'b0;
    logic [15:0] dm_out;

    dm_state_e dbg_a;
    dm_state_e dbg_b;

    dm_requester_if #(.DATA_W(16)) bus_a ();
    dm_requester_if #(.DATA_W(16)) bus_b ();

    dm_requester #(
        .DATA_W   (16),
        .SP_INIT  (16'hFFFF),
        .SP_LIMIT (16'hFFFE),
        .READ_LAT (1)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_a),
        .o_dbg_state (dbg_a)
    );

    dm_requester #(
        .DATA_W   (16),
        .SP_INIT  (16'hFFFF),
        .SP_LIMIT (16'hFF00),
        .READ_LAT (3)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_b),
        .o_dbg_state (dbg_b)
    );

    assign bus_a.cmd_valid = cmd_valid & ~sel;
    assign bus_b.cmd_valid = cmd_valid & sel;
    assign bus_a.cmd_op    = cmd_op;
    assign bus_b.cmd_op    = cmd_op;
    assign bus_a.cmd_addr  = cmd_addr;
    assign bus_b.cmd_addr  = cmd_addr;
    assign bus_a.cmd_data  = cmd_data;
    assign bus_b.cmd_data  = cmd_data;
    assign bus_a.rsp_ready = rsp_ready & ~sel;
    assign bus_b.rsp_ready = rsp_ready & sel;
    assign bus_a.dm_out    = dm_out;
    assign bus_b.dm_out    = dm_out;

    // Outputs of the selected instance; strobes packed {load,store,push,pop}
    logic [3:0]  m_strb;
    logic        m_cmd_ready, m_rsp_valid, m_rsp_err;
    logic [15:0] m_rsp_data, m_rez, m_val, m_dsp, m_sp;
    dm_state_e   m_dbg;

    assign m_strb      = sel ? {bus_b.dm_load, bus_b.dm_store, bus_b.dm_push, bus_b.dm_pop}
                             : {bus_a.dm_load, bus_a.dm_store, bus_a.dm_push, bus_a.dm_pop};
    assign m_cmd_ready = sel ? bus_b.cmd_ready : bus_a.cmd_ready;
    assign m_rsp_valid = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    assign m_rsp_err   = sel ? bus_b.rsp_err   : bus_a.rsp_err;
    assign m_rsp_data  = sel ? bus_b.rsp_data  : bus_a.rsp_data;
    assign m_rez       = sel ? bus_b.dm_rez    : bus_a.dm_rez;
    assign m_val       = sel ? bus_b.dm_val    : bus_a.dm_val;
    assign m_dsp       = sel ? bus_b.dm_sp     : bus_a.dm_sp;
    assign m_sp        = sel ? bus_b.sp        : bus_a.sp;
    assign m_dbg       = sel ? dbg_b : dbg_a;

    // ---------------- data-memory model ----------------
    // Synchronous RAM; read data is valid on dm_out only in the single cycle
    // READ_LAT cycles after the strobe, otherwise a poison value.
    logic [15:0] mem [0:65535];
    logic [2:0]  pv = 3'b000;
    logic [15:0] pd0 = '0, pd1 = '0, pd2 = '0;

    always @(posedge clk) begin
        if (m_strb[2]) mem[m_rez] <= m_val;
        if (m_strb[1]) mem[m_dsp] <= m_val;
        pv  <= {pv[1:0], (m_strb[3] | m_strb[0])};
        pd0 <= m_strb[3] ? mem[m_rez] : mem[m_dsp];
        pd1 <= pd0;
        pd2 <= pd1;
    end

    always_comb begin
        dm_out = 16'hDEAD;
        if (sel) begin
            if (pv[2]) dm_out = pd2;
        end else begin
            if (pv[0]) dm_out = pd0;
        end
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a negedge in IDLE; returns at the negedge inside ISSUE.
    task automatic issue_cmd(input string tag, input logic [1:0] op,
                             input logic [15:0] addr, input logic [15:0] data,
                             input logic [3:0] e_strb, input logic [15:0] e_rez,
                             input logic [15:0] e_val, input logic [15:0] e_dsp,
                             input logic [15:0] e_data);
        check({tag, ".ready"}, {31'd0, m_cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        exp_q.push_back(e_data);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = '0;
        cmd_data  = '0;
        check({tag, ".strb"},   {28'd0, m_strb}, {28'd0, e_strb});
        check({tag, ".rez"},    {16'd0, m_rez},  {16'd0, e_rez});
        check({tag, ".val"},    {16'd0, m_val},  {16'd0, e_val});
        check({tag, ".dm_sp"},  {16'd0, m_dsp},  {16'd0, e_dsp});
        check({tag, ".busy"},   {31'd0, m_cmd_ready}, 32'd0);
    endtask

    // Called at the ISSUE negedge; measures latency, holds off rsp_ready for
    // 'hold' cycles, then completes the response. With ovl set a STORE to
    // 0030 is offered in the same cycle as rsp_ready.
    task automatic wait_rsp(input string tag, input int e_lat, input logic e_err,
                            input logic [15:0] e_sp, input int hold, input bit ovl);
        int          lat;
        logic [15:0] e_data;
        e_data = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
        @(negedge clk);
        lat = 2;
        check({tag, ".strb_off"}, {28'd0, m_strb}, 32'd0);
        check({tag, ".bus_off"},  {16'd0, (m_rez | m_val | m_dsp)}, 32'd0);
        while (!m_rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"},  lat, e_lat);
        check({tag, ".data"}, {16'd0, m_rsp_data}, {16'd0, e_data});
        check({tag, ".err"},  {31'd0, m_rsp_err},  {31'd0, e_err});
        repeat (hold) begin
            @(negedge clk);
            check({tag, ".hold_vld"},  {31'd0, m_rsp_valid}, 32'd1);
            check({tag, ".hold_data"}, {16'd0, m_rsp_data},  {16'd0, e_data});
            check({tag, ".hold_rdy"},  {31'd0, m_cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        if (ovl) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'd1;
            cmd_addr  = 16'h0030;
            cmd_data  = 16'h00AA;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, ".vld_off"}, {31'd0, m_rsp_valid}, 32'd0);
        check({tag, ".rdy_on"},  {31'd0, m_cmd_ready}, 32'd1);
        check({tag, ".sp"},      {16'd0, m_sp}, {16'd0, e_sp});
        if (ovl) begin
            check({tag, ".no_bypass"}, {28'd0, m_strb}, 32'd0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (2) @(negedge clk);
        // Reset values while rst_n is held low
        check("rst.strb",  {28'd0, m_strb}, 32'd0);
        check("rst.ready", {31'd0, m_cmd_ready}, 32'd0);
        check("rst.vld",   {31'd0, m_rsp_valid}, 32'd0);
        check("rst.err",   {31'd0, m_rsp_err}, 32'd0);
        check("rst.data",  {16'd0, m_rsp_data}, 32'd0);
        check("rst.bus",   {16'd0, (m_rez | m_val | m_dsp)}, 32'd0);
        check("rst.sp",    {16'd0, m_sp}, 32'h0000FFFF);
        check("rst.state", {30'd0, m_dbg}, {30'd0, ST_IDLE});
        rst_n = 1'b1;
        check("rel.ready0", {31'd0, m_cmd_ready}, 32'd0);
        @(negedge clk);
        check("rel.ready1", {31'd0, m_cmd_ready}, 32'd1);

        // dut_a: STORE then LOAD
        issue_cmd("st", 2'd1, 16'h0010, 16'hBEEF, 4'b0100, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000);
        wait_rsp("st", 2, 1'b0, 16'hFFFF, 0, 1'b0);
        issue_cmd("ld", 2'd0, 16'h0010, 16'h0000, 4'b1000, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF);
        wait_rsp("ld", 3, 1'b0, 16'hFFFF, 0, 1'b0);

        // Push/push/overflow/pop/pop/underflow (limit FFFE)
        issue_cmd("push1", 2'd2, 16'h0000, 16'h1234, 4'b0010, 16'h0000, 16'h1234, 16'hFFFF, 16'h0000);
        wait_rsp("push1", 2, 1'b0, 16'hFFFE, 0, 1'b0);
        issue_cmd("push2", 2'd2, 16'h0000, 16'h5678, 4'b0010, 16'h0000, 16'h5678, 16'hFFFE, 16'h0000);
        wait_rsp("push2", 2, 1'b0, 16'hFFFD, 0, 1'b0);
        issue_cmd("ovf", 2'd2, 16'h0000, 16'h9999, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        wait_rsp("ovf", 2, 1'b1, 16'hFFFD, 0, 1'b0);
        issue_cmd("pop1", 2'd3, 16'h0000, 16'h0000, 4'b0001, 16'h0000, 16'h0000, 16'hFFFE, 16'h5678);
        wait_rsp("pop1", 3, 1'b0, 16'hFFFE, 0, 1'b0);
        issue_cmd("pop2", 2'd3, 16'h0000, 16'h0000, 4'b0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h1234);
        wait_rsp("pop2", 3, 1'b0, 16'hFFFF, 0, 1'b0);
        issue_cmd("unf", 2'd3, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        wait_rsp("unf", 2, 1'b1, 16'hFFFF, 0, 1'b0);

        // Backpressure, then a command offered together with rsp_ready
        issue_cmd("bp", 2'd0, 16'h0010, 16'h0000, 4'b1000, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF);
        wait_rsp("bp", 3, 1'b0, 16'hFFFF, 5, 1'b1);
        issue_cmd("ovl", 2'd1, 16'h0030, 16'h00AA, 4'b0100, 16'h0030, 16'h00AA, 16'h0000, 16'h0000);
        wait_rsp("ovl", 2, 1'b0, 16'hFFFF, 0, 1'b0);

        // Reset while a LOAD is in flight (sp moved first so reset is visible)
        issue_cmd("rpush", 2'd2, 16'h0000, 16'h4444, 4'b0010, 16'h0000, 16'h4444, 16'hFFFF, 16'h0000);
        wait_rsp("rpush", 2, 1'b0, 16'hFFFE, 0, 1'b0);
        issue_cmd("rld", 2'd0, 16'h0030, 16'h0000, 4'b1000, 16'h0030, 16'h0000, 16'h0000, 16'h00AA);
        rst_n = 1'b0;
        #1;
        check("arst.strb",  {28'd0, m_strb}, 32'd0);
        check("arst.sp",    {16'd0, m_sp}, 32'h0000FFFF);
        check("arst.ready", {31'd0, m_cmd_ready}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check("arel.ready0", {31'd0, m_cmd_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("arel.vld",   {31'd0, m_rsp_valid}, 32'd0);
            check("arel.ready", {31'd0, m_cmd_ready}, 32'd1);
        end

        // dut_b: READ_LAT=3
        sel = 1'b1;
        @(negedge clk);
        issue_cmd("b.st", 2'd1, 16'h0020, 16'hCAFE, 4'b0100, 16'h0020, 16'hCAFE, 16'h0000, 16'h0000);
        wait_rsp("b.st", 2, 1'b0, 16'hFFFF, 0, 1'b0);
        issue_cmd("b.ld", 2'd0, 16'h0020, 16'h0000, 4'b1000, 16'h0020, 16'h0000, 16'h0000, 16'hCAFE);
        wait_rsp("b.ld", 5, 1'b0, 16'hFFFF, 5, 1'b0);
        issue_cmd("b.push", 2'd2, 16'h0000, 16'h7777, 4'b0010, 16'h0000, 16'h7777, 16'hFFFF, 16'h0000);
        wait_rsp("b.push", 2, 1'b0, 16'hFFFE, 0, 1'b0);
        issue_cmd("b.pop", 2'd3, 16'h0000, 16'h0000, 4'b0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h7777);
        wait_rsp("b.pop", 5, 1'b0, 16'hFFFF, 0, 1'b0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
